// File: rtl/alu_seq.sv
// alu_seq: command sequencer that drives an external registered ALU for one
// or more passes, feeding each intermediate result back into operand A, and
// returns the final result over a ready/valid response channel.
// Optional feature macro: ALU_SEQ_CARRY_CHAIN_EN -- when defined, an internal
// carry flag follows the ALU carry on ADD/SUB captures and drives status0
// (cmd_cin ignored); when undefined, status0 is the cmd_cin latched at accept.
module alu_seq #(
  parameter int REP_W = 3
) (
  input  logic             clk3,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic             cmd_cin,
  output logic [3:0]       aluop,
  output logic [7:0]       alua,
  output logic [7:0]       alub,
  output logic             status0,
  input  logic [7:0]       aluout,
  input  logic             aluz,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_z,
  output logic             rsp_c,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_ROR  = 4'b0011;
  localparam logic [3:0] OP_SWAP = 4'b0111;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t           state;
  logic [REP_W-1:0] pass_cnt;
  logic             accept;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ROR, OP_SWAP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Handshake and status outputs are forced low while reset is held.
  assign cmd_ready = resetn && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = resetn && (state == DONE);
  assign busy      = resetn && (state != IDLE);

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic carry_flag;
  logic unused_cin;

  assign unused_cin = cmd_cin;
  assign status0    = carry_flag;

  // Carry flag tracks the ALU carry on every ADD/SUB capture and survives between commands.
  always_ff @(posedge clk3) begin
    if (!resetn) begin
      carry_flag <= 1'b0;
    end else if (state == CAPTURE && (aluop == OP_ADD || aluop == OP_SUB)) begin
      carry_flag <= alu_cout;
    end
  end
`else
  logic cin_q;

  assign status0 = cin_q;

  // Fill/carry bit is captured at accept and held for the whole command.
  always_ff @(posedge clk3) begin
    if (!resetn) begin
      cin_q <= 1'b0;
    end else if (accept) begin
      cin_q <= cmd_cin;
    end
  end
`endif

  // Command FSM: accept, alternate ISSUE/CAPTURE per pass, then hold the response.
  always_ff @(posedge clk3) begin
    if (!resetn) begin
      state    <= IDLE;
      aluop    <= 4'b0000;
      alua     <= 8'h00;
      alub     <= 8'h00;
      pass_cnt <= '0;
      rsp_data <= 8'h00;
      rsp_z    <= 1'b0;
      rsp_c    <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_legal(cmd_op)) begin
              aluop    <= cmd_op;
              alua     <= cmd_a;
              alub     <= cmd_b;
              pass_cnt <= cmd_rep;
              state    <= ISSUE;
            end else begin
              // Illegal opcode: ALU operands untouched, error response straight away.
              rsp_data <= 8'h00;
              rsp_z    <= 1'b0;
              rsp_c    <= 1'b0;
              rsp_err  <= 1'b1;
              state    <= DONE;
            end
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (pass_cnt != '0) begin
            // Another pass: feed the result back into operand A, B stays.
            pass_cnt <= pass_cnt - REP_W'(1);
            alua     <= aluout;
            state    <= ISSUE;
          end else begin
            rsp_data <= aluout;
            rsp_z    <= aluz;
            rsp_c    <= alu_cout;
            rsp_err  <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq with a registered
// ALU stub and a pass-level reference model of each command's response.
module tb_alu_seq;

  localparam int REP_W = 3;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  logic             clk3 = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = 4'h0;
  logic [7:0]       cmd_a = 8'h00;
  logic [7:0]       cmd_b = 8'h00;
  logic [REP_W-1:0] cmd_rep = '0;
  logic             cmd_cin = 1'b0;
  logic [3:0]       aluop;
  logic [7:0]       alua;
  logic [7:0]       alub;
  logic             status0;
  logic [7:0]       aluout = 8'h00;
  logic             aluz = 1'b0;
  logic             alu_cout = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_data;
  logic             rsp_z;
  logic             rsp_c;
  logic             rsp_err;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // reference-model state
  logic       mcarry = 1'b0;
  logic [3:0] mlast_op = 4'h0;
  logic [7:0] mlast_b = 8'h00;
  logic [7:0] exp_alua[$];

  // values captured by the last run_cmd, used by directed checks
  logic [7:0] got_data;
  logic       got_z, got_c, got_err;
  logic [3:0] got_aluop;
  int         got_lat;
  logic [7:0] got_alua[$];

  alu_seq #(.REP_W(REP_W)) dut (
    .clk3(clk3), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_rep(cmd_rep), .cmd_cin(cmd_cin),
    .aluop(aluop), .alua(alua), .alub(alub), .status0(status0),
    .aluout(aluout), .aluz(aluz), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk3 = ~clk3;

  // ALU behaviour: returns {carry, result}
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic s);
    logic [8:0] t;
    case (op)
      4'b0000: t = {1'b0, a} + {1'b0, b} + {8'd0, s};
      4'b1000: t = {1'b0, a} - {1'b0, b} - {8'd0, s};
      4'b0001: t = {1'b0, a & b};
      4'b0010: t = {1'b0, a | b};
      4'b0101: t = {1'b0, a ^ b};
      4'b0100: t = {1'b0, ~a};
      4'b0011: t = {a[0], s, a[7:1]};
      4'b0111: t = {1'b0, a[3:0], a[7:4]};
      default: t = 9'h000;
    endcase
    return t;
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0101, 4'b0100, 4'b0011, 4'b0111};
  endfunction

  // registered ALU stub, one cycle latency
  logic [8:0] alu_next;
  assign alu_next = alu_f(aluop, alua, alub, status0);
  always @(posedge clk3) begin
    aluout   <= alu_next[7:0];
    alu_cout <= alu_next[8];
    aluz     <= (alu_next[7:0] == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_aluop"}, aluop, 0);
    check({tag, "_alua"}, alua, 0);
    check({tag, "_alub"}, alub, 0);
    check({tag, "_status0"}, status0, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_z"}, rsp_z, 0);
    check({tag, "_rsp_c"}, rsp_c, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
  endtask

  task automatic model_reset();
    mcarry   = 1'b0;
    mlast_op = 4'h0;
    mlast_b  = 8'h00;
  endtask

  // Expected response of one command, pass by pass.
  task automatic model_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int rep, input logic cin,
                           output logic [7:0] ed, output logic ez, output logic ec,
                           output logic ee, output int lat);
    logic [7:0] x;
    logic [8:0] r;
    logic       s;
    exp_alua.delete();
    r = 9'h000;
    if (!is_legal(op)) begin
      ed = 8'h00; ez = 1'b0; ec = 1'b0; ee = 1'b1; lat = 1;
      return;
    end
    x = a;
    for (int i = 0; i <= rep; i++) begin
      exp_alua.push_back(x);
      s = CARRY_ON ? mcarry : cin;
      r = alu_f(op, x, b, s);
      if (CARRY_ON && (op == 4'b0000 || op == 4'b1000)) mcarry = r[8];
      x = r[7:0];
    end
    ed = r[7:0]; ez = (r[7:0] == 8'h00); ec = r[8]; ee = 1'b0;
    lat = 2 * (rep + 1) + 1;
    mlast_op = op;
    mlast_b  = b;
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [REP_W-1:0] rep, input logic cin, input int hold);
    logic [7:0] ed;
    logic       ez, ec, ee, s_first;
    int         lat, cyc;
    s_first = CARRY_ON ? mcarry : cin;
    model_cmd(op, a, b, int'(rep), cin, ed, ez, ec, ee, lat);
    got_alua.delete();
    @(negedge clk3);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_rep = rep; cmd_cin = cin;
    @(posedge clk3);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk3);
      cyc++;
      if (!rsp_valid && cyc == 1 && !ee) begin
        check("issue_aluop", aluop, op);
        check("issue_alub", alub, b);
        check("issue_status0", status0, s_first);
      end
      if (!rsp_valid && (cyc % 2) == 1) got_alua.push_back(alua);
    end while (!rsp_valid && cyc < 100);
    got_lat = cyc;
    check("latency", cyc, lat);
    got_data = rsp_data; got_z = rsp_z; got_c = rsp_c; got_err = rsp_err; got_aluop = aluop;
    check("rsp_data", rsp_data, ed);
    check("rsp_z", rsp_z, ez);
    check("rsp_c", rsp_c, ec);
    check("rsp_err", rsp_err, ee);
    if (ee) begin
      check("illegal_aluop_kept", aluop, mlast_op);
      check("illegal_alub_kept", alub, mlast_b);
    end else begin
      check("alua_pass_count", got_alua.size(), exp_alua.size());
      for (int i = 0; i < got_alua.size() && i < exp_alua.size(); i++)
        check("alua_pass", got_alua[i], exp_alua[i]);
    end
    // hold the response while a competing command is offered
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      @(negedge clk3);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, ed);
      check("hold_err", rsp_err, ee);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk3);
    #1 rsp_ready = 1'b0;
    @(negedge clk3);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ones;
    resetn = 1'b0;
    repeat (2) @(posedge clk3);
    @(negedge clk3);
    check_reset_vals("por");
    resetn = 1'b1;
    model_reset();
    @(negedge clk3);
    check("ready_after_release", cmd_ready, 1);

    // SUB equal operands
    run_cmd(4'b1000, 8'h05, 8'h05, 3'd0, 1'b0, 0);
    check("sub_data", got_data, 8'h00);
    check("sub_z", got_z, 1);
    check("sub_c", got_c, 0);

    // ADD with carry out
    run_cmd(4'b0000, 8'hF0, 8'h20, 3'd0, 1'b0, 0);
    check("add_data", got_data, 8'h10);
    check("add_c", got_c, 1);
    check("add_z", got_z, 0);
    check("add_lat", got_lat, 3);

    // carry chaining into ROR fill bit
    run_cmd(4'b0000, 8'hFF, 8'h01, 3'd0, 1'b0, 0);
    run_cmd(4'b0011, 8'h00, 8'h00, 3'd0, 1'b0, 0);
    check("chain_ror_data", got_data, CARRY_ON ? 8'h80 : 8'h00);

    // multi-pass ROR
    run_cmd(4'b0011, 8'h81, 8'h00, 3'd2, 1'b1, 0);
    check("ror_data", got_data, 8'hF0);
    check("ror_lat", got_lat, 7);
    check("ror_npass", got_alua.size(), 3);
    if (got_alua.size() == 3) begin
      check("ror_alua0", got_alua[0], 8'h81);
      check("ror_alua1", got_alua[1], 8'hC0);
      check("ror_alua2", got_alua[2], 8'hE0);
    end

    // illegal opcode with stalled response
    run_cmd(4'b0110, 8'h12, 8'h34, 3'd0, 1'b0, 5);
    check("ill_err", got_err, 1);
    check("ill_data", got_data, 8'h00);
    check("ill_lat", got_lat, 1);
    check("ill_aluop", got_aluop, 4'b0011);

    // reset during CAPTURE of a 4-pass command
    @(negedge clk3);
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 8'h11; cmd_b = 8'h22; cmd_rep = 3'd3; cmd_cin = 1'b1;
    @(posedge clk3);
    #1 cmd_valid = 1'b0;
    @(negedge clk3);
    @(negedge clk3);
    check("midop_busy", busy, 1);
    resetn = 1'b0;
    @(posedge clk3);
    @(negedge clk3);
    check_reset_vals("midop");
    resetn = 1'b1;
    model_reset();
    ones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk3);
      if (rsp_valid) ones++;
    end
    check("midop_no_rsp", ones, 0);
    check("midop_ready", cmd_ready, 1);

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      run_cmd(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
              3'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter REP_W, default 3, width of the repeat-count field.
REQ-002 SHALL have port clk3  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have cmd_valid  in  1 and cmd_ready  out  1, the command handshake.
REQ-005 SHALL have cmd_op  in  4  (ALU opcode); cmd_a  in  8 and cmd_b  in  8  (operands); cmd_rep  in  REP_W  (extra passes); cmd_cin  in  1  (fill/carry bit).
REQ-006 SHALL have aluop  out  4, alua  out  8, alub  out  8 and status0  out  1, all driving the ALU inputs.
REQ-007 SHALL have aluout  in  8, aluz  in  1 and alu_cout  in  1, the registered ALU results with 1-cycle latency.
REQ-008 SHALL have rsp_valid  out  1 and rsp_ready  in  1, the response handshake.
REQ-009 SHALL have rsp_data  out  8, rsp_z  out  1, rsp_c  out  1, rsp_err  out  1 (response payload) and busy  out  1.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, CAPTURE, DONE; busy = (state != IDLE).
REQ-011 SHALL drive cmd_ready=1 only in IDLE with resetn high; a command is accepted when cmd_valid & cmd_ready are both high at a clk3 edge.
REQ-012 SHALL treat legal opcodes as 0000 ADD, 1000 SUB, 0001 AND, 0010 OR, 0101 XOR, 0100 NOT, 0011 ROR, 0111 SWAP; every other code, including 0110, is illegal.
REQ-013 SHALL, on accept of a legal op, register op/a/b/rep into aluop/alua/alub/pass counter and go to ISSUE.
REQ-014 SHALL, on accept of an illegal op, go directly to DONE with rsp_err=1 and rsp_data=0x00, rsp_z=0, rsp_c=0, leaving aluop/alua/alub unchanged.
REQ-015 SHALL hold aluop/alua/alub/status0 stable in ISSUE and move unconditionally to CAPTURE.
REQ-016 SHALL, in CAPTURE, sample aluout/aluz/alu_cout; if pass counter != 0, decrement it, load alua <= aluout, keep alub, and return to ISSUE.
REQ-017 SHALL, in CAPTURE with pass counter == 0, load rsp_data/rsp_z/rsp_c from the sampled values, clear rsp_err, and go to DONE.
REQ-018 SHALL assert rsp_valid only in DONE and hold the payload stable until rsp_ready is high at an edge; it then returns to IDLE.
REQ-019 SHALL give a legal command rsp_valid first high 2*(rep+1)+1 cycles after the accept edge, and an illegal command 1 cycle after.
REQ-020 SHALL keep rsp_valid high indefinitely under rsp_ready=0 with no new command accepted, and SHALL NOT lose the payload.
REQ-021 SHALL have pass counter wrap impossible: it decrements only from a nonzero value, giving max 2^REP_W passes.

Reset
REQ-022 SHALL, when resetn is low at an edge, force state IDLE, aluop=0000, alua=0x00, alub=0x00, status0=0, carry flag=0, rsp_data=0x00, rsp_z=0, rsp_c=0, rsp_err=0.
REQ-023 SHALL hold rsp_valid=0, busy=0 and cmd_ready=0 while resetn is low; cmd_ready SHALL be 1 in the first cycle after release.
REQ-024 SHALL discard any in-flight command or pending response on reset mid-operation, with no response issued for it.

Configuration
REQ-025 SHALL, with macro ALU_SEQ_CARRY_CHAIN_EN defined, keep an internal carry flag updated from alu_cout in every CAPTURE of an ADD/SUB pass and persisting across commands; status0 = carry flag and cmd_cin is ignored.
REQ-026 SHALL, without ALU_SEQ_CARRY_CHAIN_EN, latch status0 = cmd_cin at accept and hold it for the whole command, with no carry flag register present.

Verification
REQ-027 SHALL cover: ADD a=0xF0 b=0x20 rep=0 -> rsp_data=0x10, rsp_c=1, rsp_z=0, rsp_valid in cycle 3.
REQ-028 SHALL cover: SUB a=0x05 b=0x05 -> rsp_data=0x00, rsp_z=1, rsp_c=0.
REQ-029 SHALL cover: ROR a=0x81 cin=1 rep=2 (macro off) -> alua sequence 0x81, 0xC0, 0xE0; rsp_data=0xF0, rsp_valid in cycle 7.
REQ-030 SHALL cover: ADD 0xFF+0x01, then ROR a=0x00 cin=0 -> macro on: rsp_data=0x80; macro off: rsp_data=0x00.
REQ-031 SHALL cover: op=0110 -> rsp_err=1, rsp_data=0x00, rsp_valid in cycle 1, aluop unchanged; then rsp_ready low 5 cycles -> payload stable, cmd_ready=0.
REQ-032 SHALL cover: resetn low for 1 cycle during CAPTURE of rep=3 command -> IDLE next cycle, no rsp_valid, all outputs at REQ-022 values.
